// File: rtl/sub_pkg.sv
// Shared constants and arithmetic helpers for the registered subtractor.
// Helpers work on 32-bit zero-extended operands; callers keep the low bits they need.
package sub_pkg;
  localparam int SUB_WL_DEF = 4;
  localparam int SUB_MAX_W  = 32;

  // Exact difference of two zero-extended unsigned operands; bit 32 is the sign.
  function automatic logic [32:0] sub_diff(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Magnitude of an exact 33-bit two's-complement difference.
  function automatic logic [31:0] sub_mag(input logic [32:0] d);
    return d[32] ? (~d[31:0] + 32'd1) : d[31:0];
  endfunction
endpackage

// File: rtl/pipe_slice.sv
// Generic valid/data pipeline register: valid follows in_vld on ld, data loads only with valid.
// Latency 1; ld is the stage-advance qualifier computed by the owner.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         iCLK,
  input  logic         iRSTn,
  input  logic         ld,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         q_vld,
  output logic [W-1:0] q_dat
);
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      q_vld <= 1'b0;
      q_dat <= '0;
    end else if (ld) begin
      q_vld <= in_vld;
      if (in_vld) q_dat <= in_dat;
    end
  end
endmodule

// File: rtl/subtractor_clock.sv
// Two-stage registered subtractor: (WL+1)-bit difference of unsigned operands, sign on oNEG.
// Latency 2 edges, one pair per clock; iREADY low stalls S2 then S1, iEN low freezes everything.
// SUBTRACTOR_ABS_EN: odata carries the magnitude (MSB 0) instead of the raw difference.
module subtractor_clock
  import sub_pkg::*;
#(
  parameter int WL = SUB_WL_DEF  // 2 <= WL < SUB_MAX_W
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iEN,
  input  logic          iVALID,
  output logic          oREADY,
  input  logic [WL-1:0] idata1,
  input  logic [WL-1:0] idata2,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [WL:0]   odata,
  output logic          oNEG
);
  localparam int PADW = SUB_MAX_W - WL;

  logic            s1_v, s2_v, s1_adv, s2_adv;
  logic [2*WL-1:0] s1_dat;
  logic [WL+1:0]   s2_dat;

  assign s2_adv = ~s2_v | iREADY;
  assign s1_adv = ~s1_v | s2_adv;
  assign oREADY = iEN & s1_adv;
  assign oVALID = s2_v;

  pipe_slice #(.W(2*WL)) u_s1 (
    .iCLK(iCLK), .iRSTn(iRSTn), .ld(iEN & s1_adv),
    .in_vld(iVALID & oREADY), .in_dat({idata1, idata2}),
    .q_vld(s1_v), .q_dat(s1_dat)
  );

  logic [32:0]        full_diff;
  logic [PADW-1:0]    diff_unused;
  logic [WL:0]        diff;
  logic [WL:0]        res;

  assign full_diff = sub_diff({{PADW{1'b0}}, s1_dat[2*WL-1:WL]}, {{PADW{1'b0}}, s1_dat[WL-1:0]});
  assign {diff_unused, diff} = full_diff;

`ifdef SUBTRACTOR_ABS_EN
  logic [SUB_MAX_W-WL-1:0] mag_unused;
  logic [WL-1:0]           mag;
  assign {mag_unused, mag} = sub_mag(full_diff);
  assign res = {1'b0, mag};
`else
  assign res = diff;
`endif

  pipe_slice #(.W(WL+2)) u_s2 (
    .iCLK(iCLK), .iRSTn(iRSTn), .ld(iEN & s2_adv),
    .in_vld(s1_v), .in_dat({diff[WL], res}),
    .q_vld(s2_v), .q_dat(s2_dat)
  );

  assign odata = s2_dat[WL:0];
  assign oNEG  = s2_dat[WL+1];
endmodule
